ha_array_accumulator: RTL and testbench
=======================================

# ha_array_accumulator

Sequential final-stage reducer for the 8x8 approximate unsigned multipliers whose partial-product generator exports four half-adder array groups. It accepts one set of the four groups (`b`/`t` vectors) via a valid/ready handshake, adds them one group per cycle into a 16-bit accumulator, and presents the product on a valid/ready output. It is the consumer end of the `ha_array_*` interface, replacing a combinational compressor tree where area matters more than throughput.

## Interface
- `BIAS`, default 16'd24: constant error-compensation offset. Used only when `HA_ACC_BIAS_EN` is defined.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a group set.
- `in_ready`  out  1  block can accept a set.
- `ha_array_0_b` .. `ha_array_3_b`  in  7 each  group g `b` vector.
- `ha_array_0_t` .. `ha_array_3_t`  in  9 each  group g `t` vector.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  16  accumulated result.
- `busy`  out  1  high in ACC or DONE.

## Operation
- Bit weights for group g (g = 0..3):
  - `t[i]` has weight 2^(2g+i).
  - `b[i]` has weight 2^(2g+i+2).
- Group term: `term_g = (t_g << 2g) + (b_g << (2g+2))`, zero-extended to 16 bits.
- All additions are modulo 2^16. Wrap-around is silent; no overflow flag.
- FSM states:
  - **IDLE**: `in_ready`=1. On `in_valid && in_ready`:
    - capture all 8 vectors into an internal register;
    - set `acc` to 0, or to `BIAS` when the macro is defined;
    - set `grp` to 0;
    - go to ACC.
  - **ACC**: each cycle, `acc <= acc + term_grp` and `grp <= grp + 1`. After the cycle that adds group 3, go to DONE. Input ports are ignored; only the captured copy is used.
  - **DONE**: `out_valid`=1 and `product`=`acc`, held stable. On `out_ready`, go to IDLE.
- `in_ready` is 0 in ACC and DONE. `in_valid` asserted there is not consumed; the producer must hold it.
- `out_ready` is ignored outside DONE.
- `busy` = (state != IDLE).
- Reset, including mid-ACC or mid-DONE:
  - state returns to IDLE and the in-flight operation is discarded;
  - `acc`, `grp`, and the capture register clear to 0;
  - outputs: `in_ready`=1, `out_valid`=0, `product`=0, `busy`=0.

## Timing
- Accept on edge E0. Groups 0..3 are added on edges E1..E4. `out_valid` rises after E4, so latency is 4 cycles from accept to output valid.
- The output handshake completes on the first edge with `out_valid && out_ready`.
- `in_ready` returns high the cycle after that edge.
- Minimum initiation interval: 6 cycles (accept, 4×ACC, DONE with `out_ready`=1, then back in IDLE).
- `product` is registered with no combinational path from inputs. It changes only on accumulator updates and otherwise holds its last value.

## Configuration
- `HA_ACC_BIAS_EN` defined: the accumulator preloads `BIAS` at accept, so `product` = (Σ `term_g` + `BIAS`) mod 2^16. This compensates the mean negative error of the approximate generator.
- `HA_ACC_BIAS_EN` undefined: the accumulator preloads 0, `BIAS` is unused, and `product` = Σ `term_g` mod 2^16.
- Latency and handshake behaviour are identical in both builds.

## Test plan
- Reset and idle (macro undefined): after reset, check `in_ready`=1, `out_valid`=0, `product`=0. Send all vectors zero → `product`=0, `out_valid` exactly 4 cycles after accept.
- Single-bit weights: send `ha_array_0_t`=9'h001 → 1. Then send `ha_array_3_t`=9'h100 → 16384. Then send `ha_array_1_b`=7'h7F → 2032.
- Wrap-around: send all `t`=9'h1FF and all `b`=7'h7F → 1019·85 = 86615 mod 65536 = 21079.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `product` stable, `out_valid`=1, `in_ready`=0. A new `in_valid` during this time is not accepted until the cycle after `out_ready`=1.
- Reset mid-operation: assert `rst_n`=0 after the second ACC cycle → immediately `out_valid`=0, `product`=0, `busy`=0. The next transaction computes correctly from zero.
- Bias build: with `HA_ACC_BIAS_EN`, `BIAS`=24, all-zero inputs → 24; `ha_array_0_t`=9'h001 → 25.

Source files
------------

// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator
// Sequential final-stage reducer for 8x8 approximate multipliers that export
// four half-adder array groups (b/t vectors). One group set is captured through
// a valid/ready handshake, the four group terms are added one per cycle into a
// 16-bit accumulator, and the result is offered on a valid/ready output.
//
// Optional feature: define HA_ACC_BIAS_EN to preload the accumulator with BIAS
// at accept (error compensation). Without it the accumulator preloads zero.

module ha_array_accumulator #(
    parameter logic [15:0] BIAS = 16'd24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  grp;
    logic [15:0] acc;
    logic [15:0] preload;
    logic [15:0] term;
    logic [2:0]  shamt;
    logic        accept;
    logic [6:0]  cap_b [4];
    logic [8:0]  cap_t [4];

`ifdef HA_ACC_BIAS_EN
    assign preload = BIAS;
`else
    // BIAS only matters in the compensated build; fold it into a sink here.
    logic unused_bias;
    assign unused_bias = ^BIAS;
    assign preload     = '0;
`endif

    assign accept  = in_valid && in_ready;
    // The product is the accumulator register itself, so it has no
    // combinational path from any input.
    assign product = acc;

    // Current group term: t at weight 2^(2g), b at weight 2^(2g+2).
    always_comb begin
        shamt = {grp, 1'b0};
        term  = ({7'd0, cap_t[grp]} << shamt) + ({7'd0, cap_b[grp], 2'b00} << shamt);
    end

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (grp == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture, preload and per-group accumulation.
    // NOTE: the small capture arrays are reset explicitly because the cleared
    // state is architecturally visible; large RAM-style arrays normally are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            grp <= '0;
            for (int g = 0; g < 4; g++) begin
                cap_b[g] <= '0;
                cap_t[g] <= '0;
            end
        end else if (accept) begin
            acc      <= preload;
            grp      <= '0;
            cap_b[0] <= ha_array_0_b;
            cap_b[1] <= ha_array_1_b;
            cap_b[2] <= ha_array_2_b;
            cap_b[3] <= ha_array_3_b;
            cap_t[0] <= ha_array_0_t;
            cap_t[1] <= ha_array_1_t;
            cap_t[2] <= ha_array_2_t;
            cap_t[3] <= ha_array_3_t;
        end else if (state == ACC) begin
            acc <= acc + term;
            grp <= grp + 2'd1;
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Self-checking bench for ha_array_accumulator: a transaction-level model
// (arithmetic sum of group terms plus a cycle count since accept) checked
// every cycle, plus directed vectors with hand-computed literal products.

module tb_ha_array_accumulator;

    localparam logic [15:0] BIAS_VAL = 16'd24;
`ifdef HA_ACC_BIAS_EN
    localparam int BIAS_ADD = 24;
`else
    localparam int BIAS_ADD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];

    int checks = 0;
    int errors = 0;

    // Model state: m_cnt 0 = idle, 1..4 = accumulating, 5 = result offered.
    int          m_cnt = 0;
    logic [15:0] m_result = '0;
    logic [15:0] m_product = '0;

    ha_array_accumulator #(.BIAS(BIAS_VAL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b_in[0]),
        .ha_array_1_b (b_in[1]),
        .ha_array_2_b (b_in[2]),
        .ha_array_3_b (b_in[3]),
        .ha_array_0_t (t_in[0]),
        .ha_array_1_t (t_in[1]),
        .ha_array_2_t (t_in[2]),
        .ha_array_3_t (t_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected product from the bit-weight rules, modulo 2^16.
    function automatic logic [15:0] model_sum();
        int sum;
        sum = BIAS_ADD;
        for (int g = 0; g < 4; g++) begin
            sum += int'(t_in[g]) * (1 << (2 * g));
            sum += int'(b_in[g]) * (1 << (2 * g + 2));
        end
        return sum[15:0];
    endfunction

    // Transaction model: accept in idle, result offered 4 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_result  <= '0;
            m_product <= '0;
        end else if (m_cnt == 0) begin
            if (in_valid) begin
                m_cnt    <= 1;
                m_result <= model_sum();
            end
        end else if (m_cnt < 5) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 4) m_product <= m_result;
        end else if (out_ready) begin
            m_cnt <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_in_ready", in_ready, m_cnt == 0);
            check("cyc_out_valid", out_valid, m_cnt == 5);
            check("cyc_busy", busy, m_cnt != 0);
            if (m_cnt == 0 || m_cnt == 5) check("cyc_product", product, m_product);
        end
    end

    task automatic load(input logic [35:0] tv, input logic [27:0] bv);
        for (int g = 0; g < 4; g++) begin
            t_in[g] = tv[9 * g +: 9];
            b_in[g] = bv[7 * g +: 7];
        end
    endtask

    // Called at a negedge; waits (bounded) for out_valid, returns edges since accept.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One full transaction with literal expectation; starts and ends at a negedge.
    task automatic send(input string name, input logic [35:0] tv, input logic [27:0] bv, input int lit);
        int lat;
        load(tv, bv);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        load({4{9'h1AA}}, {4{7'h55}});
        wait_done(lat);
        check({name, "_latency"}, lat, 4);
        check({name, "_product"}, product, (lit + BIAS_ADD) & 32'hFFFF);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        int          lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load('0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);

        // Directed vectors: t packed {t3,t2,t1,t0}, b packed {b3,b2,b1,b0}.
        send("zero", 36'h0, 28'h0, 0);
        send("t0_bit0", {9'h0, 9'h0, 9'h0, 9'h001}, 28'h0, 1);
        send("t3_bit8", {9'h100, 9'h0, 9'h0, 9'h0}, 28'h0, 16384);
        send("b1_ones", 36'h0, {7'h0, 7'h0, 7'h7F, 7'h0}, 2032);
        send("all_ones_wrap", {4{9'h1FF}}, {4{7'h7F}}, 21079);
        send("mixed", {9'h0, 9'h003, 9'h0, 9'h0}, {7'h0, 7'h0, 7'h0, 7'h01}, 52);

        // Backpressure: hold the result, with a new request pending.
        load({9'h0, 9'h0, 9'h0, 9'h005}, 28'h0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        check("bp_latency", lat, 4);
        held = product;
        check("bp_product", held, 5 + BIAS_ADD);
        load({9'h0, 9'h0, 9'h002, 9'h0}, 28'h0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_product", product, held);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_after_hs", in_ready, 1);
        check("bp_not_taken_yet", busy, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        load('0, '0);
        check("bp_accepted", busy, 1);
        wait_done(lat);
        check("bp2_latency", lat, 4);
        check("bp2_product", product, 8 + BIAS_ADD);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of accumulation.
        load({4{9'h1FF}}, {4{7'h7F}});
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_product_nonzero", product != 16'd0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_product", product, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send("after_reset", {9'h0, 9'h0, 9'h0, 9'h001}, {7'h0, 7'h0, 7'h0, 7'h01}, 5);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
